// File: rtl/ntm_scalar_subtractor.sv
// Bit-serial in1 - in2 with one borrow flop; NTM_SCALAR_SUBTRACTOR_SATURATE_EN clamps negative results to 0.
// Latency: ready pulses in the cycle after edge N+DATA_SIZE+1 for start sampled at edge N.
// Backpressure: none; start is honoured only in IDLE, requests while busy are dropped.
module ntm_scalar_subtractor #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] in1,
  input  logic [DATA_SIZE-1:0] in2,
  output logic                 busy,
  output logic                 ready,
  output logic [DATA_SIZE:0]   out
);

  localparam int CW = $clog2(DATA_SIZE);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] a_reg;
  logic [DATA_SIZE-1:0] b_reg;
  logic [DATA_SIZE-1:0] res;
  logic                 borrow;
  logic [CW-1:0]        cnt;
  logic                 d;
  logic                 borrow_nxt;

  assign d          = a_reg[0] ^ b_reg[0] ^ borrow;
  assign borrow_nxt = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      ready  <= 1'b0;
      out    <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= in1;
            b_reg  <= in2;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // LSB-first: each difference bit enters at the MSB so bit 0 lands last in place
          a_reg  <= {1'b0, a_reg[DATA_SIZE-1:1]};
          b_reg  <= {1'b0, b_reg[DATA_SIZE-1:1]};
          res    <= {d, res[DATA_SIZE-1:1]};
          borrow <= borrow_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(DATA_SIZE - 1)) state <= DONE;
        end
        DONE: begin
`ifdef NTM_SCALAR_SUBTRACTOR_SATURATE_EN
          out <= borrow ? '0 : {1'b0, res};
`else
          out <= {borrow, res};
`endif
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
